// File: rtl/iob_master.sv
// I/O bus master: runs one 68000-style asynchronous (or 6800-style VPA) bus cycle
// per slave request, generates the E clock and enforces a bus-error timeout.
module iob_master #(
    parameter int E_DIV      = 10,
    parameter int TO_CYCLES  = 255,
    parameter int REC_CYCLES = 2
) (
    input  logic CLK,
    input  logic nRES,
    input  logic IOREQ,
    input  logic IORW0,
    input  logic IOL0,
    input  logic IOU0,
    output logic IOACT,
    output logic IOBERR,
    output logic nAS_IOB,
    output logic nLDS_IOB,
    output logic nUDS_IOB,
    output logic RnW_IOB,
    output logic nVMA,
    output logic E,
    output logic nDoutOE,
    output logic DinLE,
    input  logic nDTACK_IOB,
    input  logic nVPA_IOB,
    input  logic nBERR_IOB
);
    localparam int EW = $clog2(E_DIV);
    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam int RW = $clog2(REC_CYCLES + 1);

    typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, VWAIT, VSYNC, TERM, REC} state_t;

    state_t        r_state, w_next;
    logic          r_ioreq_s1, r_ioreq_s2;
    logic          r_dtack_s, r_vpa_s, r_berr_s;
    logic [EW-1:0] r_ecnt;
    logic [TW-1:0] r_to;
    logic [RW-1:0] r_rec;
    logic          r_armed, r_rw, r_l, r_u, r_berr;
    logic          w_start, w_set_berr, w_timeout;
    logic          w_as_on, w_rd_strb, w_wr_strb;

    assign w_timeout = (r_to == TW'(TO_CYCLES - 1));
    assign E         = (r_ecnt >= EW'(E_DIV - 4));
    assign IOBERR    = r_berr;

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_ioreq_s1 <= 1'b0;
            r_ioreq_s2 <= 1'b0;
            r_dtack_s  <= 1'b1;
            r_vpa_s    <= 1'b1;
            r_berr_s   <= 1'b1;
            r_ecnt     <= '0;
        end else begin
            r_ioreq_s1 <= IOREQ;
            r_ioreq_s2 <= r_ioreq_s1;
            r_dtack_s  <= nDTACK_IOB;
            r_vpa_s    <= nVPA_IOB;
            r_berr_s   <= nBERR_IOB;
            r_ecnt     <= (r_ecnt == EW'(E_DIV - 1)) ? '0 : r_ecnt + EW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Armed requires IOREQ to be seen low before each cycle, so a slow-dropping
    // request is never serviced twice.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_armed <= 1'b0;
            r_rw    <= 1'b1;
            r_l     <= 1'b0;
            r_u     <= 1'b0;
            r_berr  <= 1'b0;
            r_to    <= '0;
            r_rec   <= '0;
        end else begin
            if (r_state == IDLE && !r_ioreq_s2) r_armed <= 1'b1;
            else if (w_start)                   r_armed <= 1'b0;
            if (w_start) begin
                r_rw   <= IORW0;
                r_l    <= IOL0;
                r_u    <= IOU0;
                r_berr <= 1'b0;
            end else if (w_set_berr) begin
                r_berr <= 1'b1;
            end
            if (r_state == S0)  r_to <= '0;
            else if (w_as_on)   r_to <= r_to + TW'(1);
            if (r_state == TERM)     r_rec <= '0;
            else if (r_state == REC) r_rec <= r_rec + RW'(1);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_set_berr = 1'b0;
        case (r_state)
            IDLE:  if (r_ioreq_s2 && r_armed) begin
                       w_next  = S0;
                       w_start = 1'b1;
                   end
            S0:    w_next = S1;
            S1:    w_next = S2;
            S2:    w_next = S3;
            S3:    if (!r_berr_s || w_timeout) begin
                       w_next     = TERM;
                       w_set_berr = 1'b1;
                   end else if (!r_dtack_s) begin
                       w_next = TERM;
                   end else if (!r_vpa_s) begin
                       w_next = VWAIT;
                   end
            VWAIT: if (w_timeout) begin
                       w_next     = TERM;
                       w_set_berr = 1'b1;
                   end else if (r_ecnt == EW'(2)) begin
                       w_next = VSYNC;
                   end
            VSYNC: if (w_timeout) begin
                       w_next     = TERM;
                       w_set_berr = 1'b1;
                   end else if (r_ecnt == EW'(E_DIV - 1)) begin
                       w_next = TERM;
                   end
            TERM:  w_next = REC;
            REC:   if (r_rec == RW'(REC_CYCLES - 1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decode from state so an async reset negates every strobe at once.
    always_comb begin
        w_as_on   = (r_state == S1) || (r_state == S2) || (r_state == S3) ||
                    (r_state == VWAIT) || (r_state == VSYNC);
        w_rd_strb = r_rw && w_as_on;
        w_wr_strb = !r_rw && ((r_state == S3) || (r_state == VWAIT) || (r_state == VSYNC));
        nAS_IOB   = !w_as_on;
        nLDS_IOB  = !(r_l && (w_rd_strb || w_wr_strb));
        nUDS_IOB  = !(r_u && (w_rd_strb || w_wr_strb));
        nVMA      = (r_state != VSYNC);
        nDoutOE   = !(!r_rw && (r_state == S2 || r_state == S3 || r_state == VWAIT ||
                                r_state == VSYNC || r_state == TERM));
        RnW_IOB   = (r_state == IDLE || r_state == REC) ? 1'b1 : r_rw;
        DinLE     = (r_state == TERM) && r_rw;
        IOACT     = (r_state != IDLE);
    end
endmodule

// File: tb/tb_iob_master.sv
// Randomized scoreboard bench for iob_master: driver queues per-cycle expectations,
// monitor measures strobe activity per bus cycle and compares on IOACT fall.
module tb_iob_master;
    localparam int E_DIV = 10, TO_CYCLES = 255, REC_CYCLES = 2;
    localparam int K_DTACK = 0, K_BERR = 1, K_BOTH = 2, K_TO = 3, K_VPA = 4;

    logic CLK = 1'b0, nRES = 1'b0;
    logic IOREQ = 1'b0, IORW0 = 1'b1, IOL0 = 1'b0, IOU0 = 1'b0;
    logic nDTACK_IOB = 1'b1, nVPA_IOB = 1'b1, nBERR_IOB = 1'b1;
    logic IOACT, IOBERR, nAS_IOB, nLDS_IOB, nUDS_IOB, RnW_IOB, nVMA, E, nDoutOE, DinLE;

    iob_master #(.E_DIV(E_DIV), .TO_CYCLES(TO_CYCLES), .REC_CYCLES(REC_CYCLES)) dut (
        .CLK(CLK), .nRES(nRES), .IOREQ(IOREQ), .IORW0(IORW0), .IOL0(IOL0), .IOU0(IOU0),
        .IOACT(IOACT), .IOBERR(IOBERR), .nAS_IOB(nAS_IOB), .nLDS_IOB(nLDS_IOB),
        .nUDS_IOB(nUDS_IOB), .RnW_IOB(RnW_IOB), .nVMA(nVMA), .E(E), .nDoutOE(nDoutOE),
        .DinLE(DinLE), .nDTACK_IOB(nDTACK_IOB), .nVPA_IOB(nVPA_IOB), .nBERR_IOB(nBERR_IOB));

    always #5 CLK = ~CLK;

    typedef struct { int kind; int d; bit rw; bit l; bit u; } exp_t;
    exp_t q[$];
    int n_vec = 0, n_err = 0;
    int resp_kind = K_DTACK, resp_d = 3;
    bit last_berr = 1'b0;
    int tb_ecnt;

    // Reference E phase: free-running 0..E_DIV-1 from reset release.
    always @(posedge CLK or negedge nRES)
        if (!nRES) tb_ecnt <= 0;
        else       tb_ecnt <= (tb_ecnt == E_DIV - 1) ? 0 : tb_ecnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Device model: answers d cycles after seeing nAS low, holds until nAS negates.
    initial begin
        int as_k;
        as_k = 0;
        forever begin
            @(negedge CLK);
            if (nAS_IOB) begin
                as_k = 0; nDTACK_IOB = 1'b1; nVPA_IOB = 1'b1; nBERR_IOB = 1'b1;
            end else begin
                as_k++;
                if (as_k == resp_d) begin
                    case (resp_kind)
                        K_DTACK: nDTACK_IOB = 1'b0;
                        K_BERR:  nBERR_IOB  = 1'b0;
                        K_BOTH:  begin nDTACK_IOB = 1'b0; nBERR_IOB = 1'b0; end
                        K_VPA:   nVPA_IOB   = 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Monitor: accumulate per-cycle activity while IOACT is high, judge on its fall.
    initial begin
        bit prev;
        int n_act, n_as, n_lds, n_uds, n_oe, n_rnw0, n_din, n_vma, vma_e;
        exp_t e;
        bit ber, vpa;
        prev = 1'b0;
        {n_act, n_as, n_lds, n_uds, n_oe, n_rnw0, n_din, n_vma, vma_e} = '0;
        forever begin
            @(negedge CLK);
            if (!nRES) begin
                prev = 1'b0;
            end else begin
                chk("E_phase", int'(E), int'(tb_ecnt >= E_DIV - 4));
                if (IOACT) begin
                    if (!prev) {n_act, n_as, n_lds, n_uds, n_oe, n_rnw0, n_din, n_vma, vma_e} = '0;
                    n_act++;
                    if (!nAS_IOB)  n_as++;
                    if (!nLDS_IOB) n_lds++;
                    if (!nUDS_IOB) n_uds++;
                    if (!nDoutOE)  n_oe++;
                    if (!RnW_IOB)  n_rnw0++;
                    if (DinLE)     n_din++;
                    if (!nVMA) begin
                        if (n_vma == 0) vma_e = tb_ecnt;
                        n_vma++;
                    end
                end else if (prev) begin
                    if (q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_cycle: got an unrequested bus cycle, expected none");
                    end else begin
                        e = q.pop_front();
                        ber = (e.kind == K_BERR) || (e.kind == K_BOTH) || (e.kind == K_TO);
                        vpa = (e.kind == K_VPA);
                        if (e.kind == K_TO)  chk("nAS_len_timeout", n_as, TO_CYCLES);
                        else if (!vpa)       chk("nAS_len", n_as, ((e.d < 2) ? 2 : e.d) + 1);
                        chk("IOACT_len", n_act, n_as + REC_CYCLES + 2);
                        chk("nLDS_len", n_lds, e.l ? (e.rw ? n_as : n_as - 2) : 0);
                        chk("nUDS_len", n_uds, e.u ? (e.rw ? n_as : n_as - 2) : 0);
                        chk("nDoutOE_len", n_oe, e.rw ? 0 : n_as);
                        chk("RnW_low_len", n_rnw0, e.rw ? 0 : n_as + 2);
                        chk("DinLE_pulses", n_din, e.rw ? 1 : 0);
                        chk("nVMA_len", n_vma, vpa ? E_DIV - 3 : 0);
                        if (vpa) chk("nVMA_start_phase", vma_e, 3);
                        chk("IOBERR", int'(IOBERR), int'(ber));
                    end
                end
                prev = IOACT;
            end
        end
    end

    task automatic run_tx(input int kind, input int d, input bit rw, input bit l, input bit u);
        exp_t e;
        bit saw, done;
        chk("IOBERR_hold", int'(IOBERR), int'(last_berr));
        e.kind = kind; e.d = d; e.rw = rw; e.l = l; e.u = u;
        q.push_back(e);
        resp_kind = kind; resp_d = d;
        IORW0 = rw; IOL0 = l; IOU0 = u;
        @(negedge CLK);
        IOREQ = 1'b1;
        saw = 1'b0; done = 1'b0;
        for (int i = 0; i < 700 && !done; i++) begin
            @(negedge CLK);
            if (IOACT) saw = 1'b1;
            else if (saw) done = 1'b1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL cycle_complete: got no IOACT rise/fall in 700 cycles, expected one cycle");
        end
        // Keep IOREQ high past completion: a re-armed master must not start again.
        repeat ($urandom_range(0, 12)) @(negedge CLK);
        IOREQ = 1'b0;
        repeat (4) @(negedge CLK);
        last_berr = (kind == K_BERR) || (kind == K_BOTH) || (kind == K_TO);
    endtask

    initial begin
        int k, w;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_state",
            int'({IOACT, IOBERR, DinLE, E, RnW_IOB, nAS_IOB, nLDS_IOB, nUDS_IOB, nVMA, nDoutOE}),
            10'b0000111111);
        @(negedge CLK);
        nRES = 1'b1;
        repeat (5) @(negedge CLK);

        run_tx(K_DTACK, 3, 1'b1, 1'b1, 1'b1);
        run_tx(K_DTACK, 2, 1'b0, 1'b0, 1'b1);
        run_tx(K_VPA,   2, 1'b1, 1'b1, 1'b1);
        run_tx(K_TO,    1, 1'b1, 1'b1, 1'b0);
        run_tx(K_BOTH,  4, 1'b0, 1'b1, 1'b1);
        run_tx(K_DTACK, 1, 1'b1, 1'b0, 1'b0);
        run_tx(K_VPA,   5, 1'b0, 1'b1, 1'b0);
        run_tx(K_BERR,  2, 1'b1, 1'b0, 1'b1);

        // Reset while the master waits in S3 for a response that never comes.
        resp_kind = K_TO; IORW0 = 1'b1; IOL0 = 1'b1; IOU0 = 1'b1;
        @(negedge CLK);
        IOREQ = 1'b1;
        w = 0;
        while (nAS_IOB && w < 20) begin @(negedge CLK); w++; end
        chk("reset_test_nAS_seen", int'(nAS_IOB), 0);
        repeat (4) @(negedge CLK);
        #2 nRES = 1'b0;
        #1;
        chk("async_reset_strobes", int'({nAS_IOB, nLDS_IOB, nUDS_IOB, nVMA, nDoutOE}), 5'b11111);
        chk("async_reset_ioact", int'(IOACT), 0);
        IOREQ = 1'b0;
        repeat (3) @(negedge CLK);
        nRES = 1'b1;
        repeat (5) @(negedge CLK);
        last_berr = 1'b0;
        run_tx(K_DTACK, 3, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            w = $urandom_range(0, 9);
            k = (w == 5) ? K_BERR : (w == 6) ? K_BOTH : (w >= 7 && w <= 8) ? K_VPA : K_DTACK;
            run_tx(k, $urandom_range(1, 6), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        run_tx(K_TO, 2, 1'b0, 1'b1, 1'b1);
        run_tx(K_DTACK, 2, 1'b1, 1'b1, 1'b0);

        repeat (5) @(negedge CLK);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iob_master.md
Name: iob_master

Overview:
- Master-side controller for the I/O bus FIFO.
- Accepts a single pending request (IOREQ with IORW0/IOL0/IOU0) from the FSB-side I/O slave. Runs one 68000-style asynchronous bus cycle on the slow I/O bus, or a 6800-style synchronous cycle when the device answers nVPA.
- Reports occupancy back to the slave through the IOACT handshake.
- Generates the I/O bus E clock and enforces a bus-error timeout.

Parameters:
- E_DIV, 10: CLK periods per E cycle. E is low for E_DIV-4 periods and high for 4 periods.
- TO_CYCLES, 255: CLK periods from nAS assertion to a forced timeout termination.
- REC_CYCLES, 2: idle CLK periods after nAS negation before the next cycle may start.

Ports:
- CLK, in, 1: I/O bus clock.
- nRES, in, 1: asynchronous active-low reset.
- IOREQ, in, 1: request from the slave; asynchronous to CLK.
- IORW0, in, 1: 1 = read, 0 = write. Stable while IOREQ=1.
- IOL0, in, 1: lower byte enable.
- IOU0, in, 1: upper byte enable.
- IOACT, out, 1: cycle in progress.
- IOBERR, out, 1: last cycle ended by nBERR or timeout.
- nAS_IOB, out, 1: address strobe.
- nLDS_IOB, out, 1: lower data strobe.
- nUDS_IOB, out, 1: upper data strobe.
- RnW_IOB, out, 1: bus direction.
- nVMA, out, 1: valid memory address (6800 cycles).
- E, out, 1: E clock.
- nDoutOE, out, 1: write data buffer enable.
- DinLE, out, 1: read data latch enable; one-cycle pulse.
- nDTACK_IOB, in, 1: device acknowledge.
- nVPA_IOB, in, 1: valid peripheral address.
- nBERR_IOB, in, 1: device bus error.

Behaviour:
- Reset values: IOACT=0, IOBERR=0, DinLE=0, E=0, RnW_IOB=1. nAS_IOB, nLDS_IOB, nUDS_IOB, nVMA and nDoutOE all =1. The E counter is 0 and the FSM is in IDLE.
- Reset mid-cycle: all strobes negate asynchronously. No handshake completion is owed to the slave; the slave is reset by the same system reset.
- Synchronisers:
  - IOREQ passes through two flops (IOREQs).
  - nDTACK_IOB, nVPA_IOB and nBERR_IOB pass through one flop each.
- E counter: free-running 0..E_DIV-1; wraps to 0. E=1 when cnt >= E_DIV-4. Runs regardless of FSM state.
- Armed flag:
  - Set when IOREQs=0 is sampled in IDLE.
  - Cleared on cycle start.
  - A new cycle starts only when Armed=1. This prevents a request being issued twice while the slave is still dropping IOREQ.
- FSM states:
  - IDLE: when IOREQs && Armed, go to S0. Latch IORW0/IOL0/IOU0, set IOACT=1, clear IOBERR.
  - S0: RnW_IOB=IORW latched. Go to S1.
  - S1: nAS_IOB=0. On reads, the data strobes (LDS/UDS per latched enables) also assert now. Start the timeout counter. Go to S2.
  - S2: on writes, nDoutOE=0 now, then go to S3.
  - S3: write data strobes assert here. Wait state. Priority of terminations (highest first):
    1. nBERR low or timeout: IOBERR=1, go to TERM.
    2. nDTACK low: go to TERM.
    3. nVPA low: go to VWAIT.
  - VWAIT: wait for E cnt==2, then nVMA=0 and go to VSYNC.
  - VSYNC: wait for E cnt==E_DIV-1 (last high period), then go to TERM.
  - TERM: DinLE=1 for one cycle if a read. Negate nAS, data strobes and nVMA. nDoutOE stays low this cycle. Go to REC.
  - REC: nDoutOE=1. Hold for REC_CYCLES. IOACT=0 on REC exit, then go to IDLE.
- The timeout counter keeps running in VWAIT/VSYNC. Timeout overrides VPA, but VPA takes effect only if the 6800 sequence completes first.
- If both enables are 0, the cycle runs with no data strobes and terminates normally.
- IOREQ negation mid-cycle is ignored; the cycle always completes.
- IOBERR holds its value until the next cycle starts.

Test Plan:
- Read, IOL0=IOU0=1, DTACK returned 3 cycles after nAS -> both strobes low from S1; DinLE pulses at TERM; IOACT high from IDLE exit through REC (2 cycles); IOBERR=0.
- Write, IOU0 only -> nDoutOE low in S2 through TERM; only nUDS asserts, from S3; RnW_IOB=0; nLDS stays 1.
- nVPA read with E cnt=5 on VPA sample -> nVMA waits for cnt==2 of the next E cycle; TERM after cnt==9; E period exactly 10 CLK.
- No response -> termination at 255 cycles after nAS; IOBERR=1 until the next request; DTACK with nBERR in the same cycle -> IOBERR=1.
- IOREQ held high across REC and IDLE -> no second cycle until IOREQ is seen low and then high again.
- nRES asserted in S3 -> all strobes 1 and IOACT=0 immediately, without waiting for a CLK edge; after release, a normal read succeeds.
